// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation select encodings.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_RSV6  = 3'b110,
    MODE_RSV7  = 3'b111
  } mode_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on RESET or CLR, counts INC pulses and sticks at MAX.
module sat_counter #(
  parameter int MAX = 16,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CLR,
  input  logic          INC,
  output logic [CW-1:0] COUNT
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] count_r;

  // Count register; clear wins over increment, increment stops at MAX.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_r <= {CW{1'b0}};
    end else if (CLR) begin
      count_r <= {CW{1'b0}};
    end else if (INC && (count_r != MAX_C)) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign COUNT = count_r;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift/rotate left/right and parallel load, with a
// registered serial-out bit and a saturating count of shift/rotate operations.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               CW          = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic             SER_IN,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic [WIDTH-1:0] OUT,
  output logic             SER_OUT,
  output logic [CW-1:0]    COUNT,
  output logic             DONE
);

  localparam logic [CW-1:0] FULL_C = CW'(WIDTH);

  mode_e            mode_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] next_data_s;
  logic             ser_out_r;
  logic             next_ser_s;
  logic             inc_s;
  logic             clr_s;
  logic [CW-1:0]    count_s;

  assign mode_s = mode_e'(MODE);

  // Next-state selection for data, serial-out bit and counter controls.
  always_comb begin
    next_data_s = data_r;
    next_ser_s  = ser_out_r;
    inc_s       = 1'b0;
    clr_s       = 1'b0;
    if (EN) begin
      case (mode_s)
        MODE_SHL: begin
          next_data_s = {data_r[WIDTH-2:0], SER_IN};
          next_ser_s  = data_r[WIDTH-1];
          inc_s       = 1'b1;
        end
        MODE_SHR: begin
          next_data_s = {SER_IN, data_r[WIDTH-1:1]};
          next_ser_s  = data_r[0];
          inc_s       = 1'b1;
        end
        MODE_ROL: begin
          next_data_s = {data_r[WIDTH-2:0], data_r[WIDTH-1]};
          next_ser_s  = data_r[WIDTH-1];
          inc_s       = 1'b1;
        end
        MODE_ROR: begin
          next_data_s = {data_r[0], data_r[WIDTH-1:1]};
          next_ser_s  = data_r[0];
          inc_s       = 1'b1;
        end
        MODE_LOAD: begin
          next_data_s = LOAD_DATA;
          next_ser_s  = 1'b0;
          clr_s       = 1'b1;
        end
        default: begin
          next_data_s = data_r;
          next_ser_s  = ser_out_r;
        end
      endcase
    end else begin
      next_data_s = data_r;
      next_ser_s  = ser_out_r;
    end
  end

  // Data and serial-out registers; reset overrides any pending operation.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_r    <= RESET_VALUE;
      ser_out_r <= 1'b0;
    end else begin
      data_r    <= next_data_s;
      ser_out_r <= next_ser_s;
    end
  end

  sat_counter #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_sat_counter (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (clr_s),
    .INC   (inc_s),
    .COUNT (count_s)
  );

  assign OUT     = data_r;
  assign SER_OUT = ser_out_r;
  assign COUNT   = count_s;
  assign DONE    = (count_s == FULL_C);

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
- REQ-001: Parameter WIDTH, default 16, register width in bits; SHALL be at least 2.
- REQ-002: Parameter RESET_VALUE, default all zeros, WIDTH-bit value loaded into OUT on reset.
- REQ-003: Port CLK, input, width 1, the single clock; all state SHALL update on its rising edge.
- REQ-004: Port RESET, input, width 1, reset; synchronous, active-high.
- REQ-005: Port EN, input, width 1, operation enable.
- REQ-006: Port MODE, input, width 3, operation select.
- REQ-007: Port SER_IN, input, width 1, serial data in for shift modes.
- REQ-008: Port LOAD_DATA, input, width WIDTH, parallel load value.
- REQ-009: Port OUT, output, width WIDTH, register contents.
- REQ-010: Port SER_OUT, output, width 1, registered copy of the bit expelled by the most recent shift or rotate.
- REQ-011: Port COUNT, output, width clog2(WIDTH+1), number of shift/rotate operations since the last reset or load, saturating.
- REQ-012: Port DONE, output, width 1, high while COUNT equals WIDTH.

Function
- REQ-013: MODE encoding SHALL be: 000 hold; 001 shift left; 010 shift right; 011 rotate left; 100 rotate right; 101 parallel load; 110 and 111 reserved.
- REQ-014: Shift left SHALL set OUT to {OUT[WIDTH-2:0], SER_IN} and SER_OUT to the old OUT[WIDTH-1].
- REQ-015: Shift right SHALL set OUT to {SER_IN, OUT[WIDTH-1:1]} and SER_OUT to the old OUT[0].
- REQ-016: Rotate left SHALL set OUT to {OUT[WIDTH-2:0], OUT[WIDTH-1]}, with SER_OUT taking the old OUT[WIDTH-1].
- REQ-017: Rotate right SHALL set OUT to {OUT[0], OUT[WIDTH-1:1]}, with SER_OUT taking the old OUT[0].
- REQ-018: Parallel load SHALL set OUT to LOAD_DATA, clear SER_OUT and clear COUNT.
- REQ-019: Hold and the reserved modes SHALL leave OUT, SER_OUT and COUNT unchanged.
- REQ-020: Every operation SHALL have one-cycle latency: the result is visible on OUT after the rising edge at which MODE is sampled.
- REQ-021: When EN is low, all state SHALL hold regardless of MODE, SER_IN and LOAD_DATA.
- REQ-022: Each enabled shift or rotate SHALL increment COUNT by 1, up to a maximum of WIDTH.
- REQ-023: COUNT SHALL saturate at WIDTH and never wrap. Further shifts still move the data, and COUNT and DONE stay at WIDTH and 1.
- REQ-024: DONE SHALL be combinationally decoded from registered COUNT, and therefore has no extra latency relative to COUNT.

Reset
- REQ-025: When RESET is high at a rising edge, the block SHALL set OUT to RESET_VALUE and clear SER_OUT and COUNT; DONE is consequently 0.
- REQ-026: RESET SHALL take priority over EN and every MODE, including mid-sequence, with no partial shift retained.
- REQ-027: Outputs SHALL be undefined only before the first reset edge; no asynchronous path from RESET SHALL exist.

Structure
- REQ-028: The MODE encodings SHALL be defined as named constants in the shared package shift_pkg, which is used by both the RTL and the bench.
- REQ-029: The saturating counter SHALL be a separate sub-module named sat_counter, parametrised by MAX (equal to WIDTH), with inputs CLK, RESET, CLR and INC and output COUNT.
- REQ-030: The data path SHALL be a single registered WIDTH-bit vector, with the next value selected by a case on MODE.

Verification (WIDTH=16, RESET_VALUE=0)
- REQ-031: Assert RESET for one edge with EN=1 and MODE=101 and LOAD_DATA=0xFFFF. Required: OUT=0x0000, COUNT=0, DONE=0, SER_OUT=0.
- REQ-032: Apply EN=1, MODE=001 and SER_IN=1 for 4 edges. Required: OUT=0x000F, COUNT=4, SER_OUT=0.
- REQ-033: Load 0x8001, then apply MODE=100 for 1 edge. Required: OUT=0xC000, SER_OUT=1, COUNT=1.
- REQ-034: Load 0xFFFF, then apply MODE=010 with SER_IN=0:
  - after 16 edges: OUT=0x0000, COUNT=16, DONE=1;
  - on the 17th edge: COUNT remains 16 and SER_OUT=0.
- REQ-035: During a shift sequence with COUNT=7, set EN=0 with MODE=101 and LOAD_DATA=0x1234. Required: OUT, COUNT and SER_OUT are unchanged.
- REQ-036: Assert RESET with MODE=011 active. Required: OUT=0x0000 and COUNT=0 on the following cycle.
